// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit that owns HI/LO for the multi-cycle MIPS core.
// Build option: define MULDIV_EARLY_TERM_EN to let multiplies stop once the multiplier is exhausted.
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // state | meaning
    // IDLE  | waiting for start; mthi/mtlo accepted
    // CALC  | one shift/add or shift/subtract iteration per cycle
    // FIX   | sign correction, HI/LO written at the closing edge
    // DONE  | done pulse (with div_zero when flagged)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic               is_div;
    logic               neg_res;
    logic               neg_rem;

    logic               sgn_op;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               launch;
    logic               zero_div;

    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] mcand_nxt;
    logic [WIDTH-1:0]   mplier_nxt;
    logic [WIDTH-1:0]   div_sh;
    logic [WIDTH:0]     div_diff;
    logic               last_iter;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    // Signed ops run on magnitudes; 0x8000_0000 maps to itself, which is the correct unsigned magnitude.
    assign sgn_op   = ~op[0];
    assign a_neg    = sgn_op & op_a[WIDTH-1];
    assign b_neg    = sgn_op & op_b[WIDTH-1];
    assign a_mag    = a_neg ? -op_a : op_a;
    assign b_mag    = b_neg ? -op_b : op_b;
    assign launch   = (state == IDLE) && start && !abort;
    assign zero_div = op[1] && (op_b == '0);

    // Divide keeps {remainder, quotient/dividend} in acc and the divisor in mcand[WIDTH-1:0].
    always_comb begin
        acc_nxt    = acc;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        div_sh     = '0;
        div_diff   = '0;
        if (is_div) begin
            div_sh   = {acc[2*WIDTH-2:WIDTH], acc[WIDTH-1]};
            div_diff = {acc[2*WIDTH-1], div_sh} - {1'b0, mcand[WIDTH-1:0]};
            if (!div_diff[WIDTH]) begin
                acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {div_sh, acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt    = acc + (mplier[0] ? mcand : '0);
            mcand_nxt  = mcand << 1;
            mplier_nxt = mplier >> 1;
        end
    end

    always_comb begin
        last_iter = (cnt == LAST_ITER);
`ifdef MULDIV_EARLY_TERM_EN
        if (!is_div && (mplier_nxt == '0)) begin
            last_iter = 1'b1;
        end
`endif
    end

    assign prod_fix = neg_res ? -acc : acc;
    assign quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_wr) begin
                        hi <= wr_data;
                    end
                    if (lo_wr) begin
                        lo <= wr_data;
                    end
                    if (launch) begin
                        is_div  <= op[1];
                        neg_res <= a_neg ^ b_neg;
                        neg_rem <= a_neg;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        if (zero_div) begin
                            // Result overrides a same-cycle mthi/mtlo.
                            hi       <= op_a;
                            lo       <= '1;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                            if (op[1]) begin
                                acc    <= {{WIDTH{1'b0}}, a_mag};
                                mcand  <= {{WIDTH{1'b0}}, b_mag};
                                mplier <= '0;
                            end else begin
                                acc    <= '0;
                                mcand  <= {{WIDTH{1'b0}}, a_mag};
                                mplier <= b_mag;
                            end
                        end
                    end
                end
                CALC: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc    <= acc_nxt;
                        mcand  <= mcand_nxt;
                        mplier <= mplier_nxt;
                        cnt    <= cnt + 1'b1;
                        if (last_iter) begin
                            state <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (is_div) begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end else begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: hand-computed products, quotients, latencies and HI/LO side effects.
// Multiply latencies follow MULDIV_EARLY_TERM_EN when the bench is built with it.
module tb_muldiv_seq;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        abort;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_fails  = 0;

    muldiv_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .op_a     (op_a),
        .op_b     (op_b),
        .abort    (abort),
        .hi_wr    (hi_wr),
        .lo_wr    (lo_wr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles from start to DONE for a multiply, given the multiplier magnitude.
    function automatic int mul_lat(input logic [31:0] bmag);
`ifdef MULDIV_EARLY_TERM_EN
        int n = 0;
        for (int i = 0; i < 32; i++) begin
            if (bmag[i]) n = i + 1;
        end
        return 2 + ((n < 1) ? 1 : n);
`else
        return 34;
`endif
    endfunction

    // Start pulse in cycle 0; returns at the sampling point of cycle 1.
    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic hw, input logic [31:0] wd);
        @(negedge clk);
        start = 1'b1; op = o; op_a = a; op_b = b; hi_wr = hw; wr_data = wd;
        @(negedge clk);
        start = 1'b0; hi_wr = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 80) begin
            check({tag, " busy"}, 64'(busy), 64'd1);
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] eh,
                          input logic [31:0] el, input logic edz);
        int cyc;
        launch(o, a, b, 1'b0, 32'h0);
        wait_done(tag, cyc);
        check({tag, " latency"}, 64'(cyc), 64'(lat));
        check({tag, " busy at done"}, 64'(busy), 64'd1);
        check({tag, " div_zero"}, 64'(div_zero), 64'(edz));
        check({tag, " hi"}, 64'(hi), 64'(eh));
        check({tag, " lo"}, 64'(lo), 64'(el));
        @(negedge clk);
        check({tag, " done cleared"}, 64'(done), 64'd0);
        check({tag, " busy cleared"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int cyc;
        int done_cnt;
        int done_cyc;
        logic [31:0] hi_at;
        logic [31:0] lo_at;

        rst = 1'b1; start = 1'b0; op = 2'b00; op_a = '0; op_b = '0;
        abort = 1'b0; hi_wr = 1'b0; lo_wr = 1'b0; wr_data = '0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset hi", 64'(hi), 64'd0);
        check("reset lo", 64'(lo), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset div_zero", 64'(div_zero), 64'd0);
        rst = 1'b1;

        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, mul_lat(32'hFFFF_FFFF),
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);

        @(negedge clk); hi_wr = 1'b1; wr_data = 32'hA5A5_A5A5;
        @(negedge clk); hi_wr = 1'b0;
        check("mthi hi", 64'(hi), 64'h0000_0000_A5A5_A5A5);
        check("mthi lo kept", 64'(lo), 64'h0000_0000_0000_0001);
        lo_wr = 1'b1; wr_data = 32'h0F0F_0F0F;
        @(negedge clk); lo_wr = 1'b0;
        check("mtlo lo", 64'(lo), 64'h0000_0000_0F0F_0F0F);
        check("mtlo hi kept", 64'(hi), 64'h0000_0000_A5A5_A5A5);

        run_op("mult -7*3", OP_MULT, 32'hFFFF_FFF9, 32'd3, mul_lat(32'd3),
               32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu 7/2", OP_DIVU, 32'd7, 32'd2, 34, 32'd1, 32'd3, 1'b0);
        run_op("divu by zero", OP_DIVU, 32'h0000_1234, 32'd0, 1, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("div minint/-1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0, 32'h8000_0000, 1'b0);
        run_op("mult minint^2", OP_MULT, 32'h8000_0000, 32'h8000_0000, mul_lat(32'h8000_0000),
               32'h4000_0000, 32'h0000_0000, 1'b0);
        run_op("mult by zero", OP_MULT, 32'd12345, 32'd0, mul_lat(32'd0), 32'd0, 32'd0, 1'b0);
        run_op("mult -1*5", OP_MULT, 32'hFFFF_FFFF, 32'd5, mul_lat(32'd5),
               32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        run_op("div 7/-2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 34, 32'd1, 32'hFFFF_FFFD, 1'b0);
        run_op("divu big/16", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 34, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        run_op("div 5/0", OP_DIV, 32'd5, 32'd0, 1, 32'd5, 32'hFFFF_FFFF, 1'b1);

        // mthi in the same IDLE cycle as start: mthi lands first, result overwrites later
        launch(OP_DIVU, 32'd9, 32'd4, 1'b1, 32'h5555_0000);
        check("start+mthi early hi", 64'(hi), 64'h0000_0000_5555_0000);
        wait_done("start+mthi", cyc);
        check("start+mthi latency", 64'(cyc), 64'd34);
        check("start+mthi hi", 64'(hi), 64'd1);
        check("start+mthi lo", 64'(lo), 64'd2);

        @(negedge clk); hi_wr = 1'b1; lo_wr = 1'b1; wr_data = 32'h3C3C_3C3C;
        @(negedge clk); hi_wr = 1'b0; lo_wr = 1'b0;
        check("mthi+mtlo hi", 64'(hi), 64'h0000_0000_3C3C_3C3C);
        check("mthi+mtlo lo", 64'(lo), 64'h0000_0000_3C3C_3C3C);

        // mthi and a second start during CALC are both dropped
        launch(OP_DIVU, 32'd7, 32'd2, 1'b0, 32'h0);
        done_cnt = 0; done_cyc = 0; hi_at = '0; lo_at = '0;
        for (int c = 1; c <= 50; c++) begin
            if (done === 1'b1) begin
                done_cnt++; done_cyc = c; hi_at = hi; lo_at = lo;
            end
            if (c == 5) begin
                hi_wr = 1'b1; wr_data = 32'hDEAD_BEEF;
            end
            if (c == 6) begin
                hi_wr = 1'b0;
                check("calc mthi dropped", 64'(hi), 64'h0000_0000_3C3C_3C3C);
                start = 1'b1; op = OP_MULTU; op_a = 32'd5; op_b = 32'd5;
            end
            if (c == 7) start = 1'b0;
            @(negedge clk);
        end
        check("busy start ignored done count", 64'(done_cnt), 64'd1);
        check("busy start ignored done cycle", 64'(done_cyc), 64'd34);
        check("busy start ignored hi", 64'(hi_at), 64'd1);
        check("busy start ignored lo", 64'(lo_at), 64'd3);
        check("no queued op lo", 64'(lo), 64'd3);

        // abort in CALC
        hi_wr = 1'b1; wr_data = 32'h1111_1111;
        @(negedge clk); hi_wr = 1'b0; lo_wr = 1'b1; wr_data = 32'h2222_2222;
        @(negedge clk); lo_wr = 1'b0;
        launch(OP_MULT, 32'h0000_1234, 32'h7FFF_FFFF, 1'b0, 32'h0);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort busy cycle 11", 64'(busy), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort no done", 64'(done_cnt), 64'd0);
        check("abort hi kept", 64'(hi), 64'h0000_0000_1111_1111);
        check("abort lo kept", 64'(lo), 64'h0000_0000_2222_2222);

        // abort together with start in IDLE suppresses the start
        start = 1'b1; abort = 1'b1; op = OP_DIVU; op_a = 32'd50; op_b = 32'd5;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("abort+start busy", 64'(busy), 64'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("abort+start no done", 64'(done_cnt), 64'd0);
        check("abort+start lo kept", 64'(lo), 64'h0000_0000_2222_2222);

        // abort in DONE has no effect
        launch(OP_DIVU, 32'h0000_0099, 32'd0, 1'b0, 32'h0);
        check("abort in done done", 64'(done), 64'd1);
        check("abort in done flag", 64'(div_zero), 64'd1);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        check("abort in done hi", 64'(hi), 64'h0000_0000_0000_0099);
        check("abort in done lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);

        // reset in cycle 20 of a divide
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'h0);
        repeat (19) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midop reset hi", 64'(hi), 64'd0);
        check("midop reset lo", 64'(lo), 64'd0);
        check("midop reset busy", 64'(busy), 64'd0);
        @(negedge clk); rst = 1'b1;

        run_op("divu after reset", OP_DIVU, 32'd100, 32'd7, 34, 32'd2, 32'd14, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
